// File: rtl/verdict_pkg.sv
// Shared sizing helpers and encodings for the verdict capture FIFO.
// An entry is packed as {ts, aktv, val} with val at bit 0.
package verdict_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int entry_w(input int ts_w, input int n_out, input int data_w);
    return ts_w + n_out + n_out * data_w;
  endfunction

  function automatic int aktv_lsb(input int n_out, input int data_w);
    return n_out * data_w;
  endfunction

  function automatic int ts_lsb(input int n_out, input int data_w);
    return n_out * data_w + n_out;
  endfunction

  localparam int VAL_LSB = 0;
  // Entry width for the default configuration (TS_W=32, N_OUT=12, DATA_W=64).
  localparam int ENTRY_W = entry_w(32, 12, 64);

endpackage

// File: rtl/verdict_capture_fifo_if.sv
// Read-side valid/ready port of the verdict capture FIFO.
interface verdict_capture_fifo_if #(
  parameter int TS_W   = 32,
  parameter int N_OUT  = 12,
  parameter int DATA_W = 64
);
  logic                    rd_valid;
  logic                    rd_ready;
  logic [TS_W-1:0]         rd_ts;
  logic [N_OUT-1:0]        rd_aktv;
  logic [N_OUT*DATA_W-1:0] rd_val;

  modport master (output rd_valid, rd_ts, rd_aktv, rd_val, input rd_ready);
  modport slave  (input rd_valid, rd_ts, rd_aktv, rd_val, output rd_ready);
endinterface

// File: rtl/verdict_fifo_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
module verdict_fifo_mem
  import verdict_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/verdict_capture_fifo.sv
// Captures every enabled cycle with any active monitor stream into a FIFO
// with a registered first-word-fallthrough read port and a drop counter.
module verdict_capture_fifo
  import verdict_pkg::*;
#(
  parameter int N_OUT    = 12,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 32,
  parameter bit DROP_OLD = 1'b0,
  parameter int CNT_W    = 16,
  localparam int AW      = clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_OUT*DATA_W-1:0] out_val,
  input  logic [N_OUT-1:0]        out_aktv,
  verdict_capture_fifo_if.master  rd,
  output logic [CW-1:0]           count,
  output logic                    full,
  output logic [CNT_W-1:0]        drop_cnt
);
  localparam int EW = entry_w(TS_W, N_OUT, DATA_W);
  localparam int AL = aktv_lsb(N_OUT, DATA_W);
  localparam int TL = ts_lsb(N_OUT, DATA_W);

  fifo_state_t   state;
  logic [TS_W-1:0] ts;
  logic [AW-1:0] wptr, rptr, rptr_nx;
  logic [CW-1:0] count_nx;
  logic [EW-1:0] wr_entry, mem_rdata, head_nx, head_q;
  logic          rd_valid_q;
  logic          push, pop, is_full, wr, adv, lost;

  always_comb begin
    push     = en && (|out_aktv);
    pop      = rd_valid_q && rd.rd_ready;
    is_full  = (state == ST_FULL);
    // A full FIFO accepts a capture if a pop frees a slot or if we evict the head.
    wr       = push && (!is_full || pop || DROP_OLD);
    adv      = pop || (push && is_full && DROP_OLD);
    lost     = push && is_full && !pop;
    rptr_nx  = adv ? rptr + AW'(1) : rptr;
    count_nx = count + CW'(wr) - CW'(adv);
    wr_entry = {ts, out_aktv, out_val};
    // The head for next cycle may be the entry being written this edge.
    head_nx  = (wr && (wptr == rptr_nx)) ? wr_entry : mem_rdata;
  end

  verdict_fifo_mem #(.DEPTH(DEPTH), .W(EW), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wptr),
    .wdata (wr_entry),
    .raddr (rptr_nx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      ts         <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      head_q     <= '0;
      rd_valid_q <= 1'b0;
      full       <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (en) ts <= ts + TS_W'(1);
      if (wr) wptr <= wptr + AW'(1);
      rptr   <= rptr_nx;
      count  <= count_nx;
      head_q <= head_nx;
      if (lost && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
      case (state)
        ST_EMPTY: if (wr) state <= ST_PARTIAL;
        ST_PARTIAL:
          if (wr && !adv && (count == CW'(DEPTH - 1))) state <= ST_FULL;
          else if (adv && !wr && (count == CW'(1)))    state <= ST_EMPTY;
        ST_FULL: if (adv && !wr) state <= ST_PARTIAL;
        default: state <= ST_EMPTY;
      endcase
      rd_valid_q <= (count_nx != '0);
      full       <= (count_nx == CW'(DEPTH));
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_ts    = head_q[TL +: TS_W];
  assign rd.rd_aktv  = head_q[AL +: N_OUT];
  assign rd.rd_val   = head_q[VAL_LSB +: N_OUT*DATA_W];
endmodule

// File: tb/tb_verdict_capture_fifo.sv
// Two DEPTH=4 instances (discard-new and overwrite-oldest) against a queue model.
module tb_verdict_capture_fifo;
  localparam int N   = 12;
  localparam int DW  = 64;
  localparam int D   = 4;
  localparam int TW  = 32;
  localparam int CNW = 16;

  typedef struct {
    logic [TW-1:0]   ts;
    logic [N-1:0]    aktv;
    logic [N*DW-1:0] val;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [N*DW-1:0] val;
  logic [N-1:0]    aktv;
  logic [2:0]      count0, count1;
  logic            full0, full1;
  logic [CNW-1:0]  drop0, drop1;

  verdict_capture_fifo_if #(.TS_W(TW), .N_OUT(N), .DATA_W(DW)) rif0 ();
  verdict_capture_fifo_if #(.TS_W(TW), .N_OUT(N), .DATA_W(DW)) rif1 ();

  verdict_capture_fifo #(.N_OUT(N), .DATA_W(DW), .DEPTH(D), .TS_W(TW), .DROP_OLD(1'b0), .CNT_W(CNW)) dut0 (
    .clk(clk), .rst(rst), .en(en), .out_val(val), .out_aktv(aktv),
    .rd(rif0.master), .count(count0), .full(full0), .drop_cnt(drop0));

  verdict_capture_fifo #(.N_OUT(N), .DATA_W(DW), .DEPTH(D), .TS_W(TW), .DROP_OLD(1'b1), .CNT_W(CNW)) dut1 (
    .clk(clk), .rst(rst), .en(en), .out_val(val), .out_aktv(aktv),
    .rd(rif1.master), .count(count1), .full(full1), .drop_cnt(drop1));

  always #5 clk = ~clk;

  ent_t        q0[$], q1[$];
  int          mdrop0, mdrop1;
  logic [TW-1:0] mts;
  int          errs = 0;
  int          n = 0;

  // Reference: pop first (frees a slot), then capture under the overflow policy.
  task automatic model_update();
    ent_t e;
    if (rst) begin
      q0.delete(); q1.delete(); mdrop0 = 0; mdrop1 = 0; mts = '0;
    end else begin
      e.ts = mts; e.aktv = aktv; e.val = val;
      if (q0.size() > 0 && rif0.rd_ready) void'(q0.pop_front());
      if (q1.size() > 0 && rif1.rd_ready) void'(q1.pop_front());
      if (en && aktv != '0) begin
        if (q0.size() < D) q0.push_back(e);
        else mdrop0++;
        if (q1.size() < D) q1.push_back(e);
        else begin void'(q1.pop_front()); q1.push_back(e); mdrop1++; end
      end
      if (en) mts = mts + 1;
    end
  endtask

  task automatic chk_inst(input int k, input ent_t hd, input int sz, input int md,
                          input logic v, input logic [2:0] c, input logic f,
                          input logic [CNW-1:0] d, input logic [TW-1:0] ts,
                          input logic [N-1:0] ak, input logic [N*DW-1:0] vl);
    n++; assert (v === (sz != 0)) else begin errs++; $error("FAIL rd_valid%0d got %b exp %b", k, v, sz != 0); end
    n++; assert (c === 3'(sz)) else begin errs++; $error("FAIL count%0d got %0d exp %0d", k, c, sz); end
    n++; assert (f === (sz == D)) else begin errs++; $error("FAIL full%0d got %b exp %b", k, f, sz == D); end
    n++; assert (d === CNW'(md)) else begin errs++; $error("FAIL drop_cnt%0d got %0d exp %0d", k, d, md); end
    if (sz != 0) begin
      n++; assert (ts === hd.ts) else begin errs++; $error("FAIL rd_ts%0d got %0d exp %0d", k, ts, hd.ts); end
      n++; assert (ak === hd.aktv) else begin errs++; $error("FAIL rd_aktv%0d got %h exp %h", k, ak, hd.aktv); end
      n++; assert (vl === hd.val) else begin errs++; $error("FAIL rd_val%0d got %h exp %h", k, vl, hd.val); end
    end
  endtask

  task automatic check_all();
    ent_t h0, h1;
    h0 = '{default: '0}; h1 = '{default: '0};
    if (q0.size() > 0) h0 = q0[0];
    if (q1.size() > 0) h1 = q1[0];
    chk_inst(0, h0, q0.size(), mdrop0, rif0.rd_valid, count0, full0, drop0, rif0.rd_ts, rif0.rd_aktv, rif0.rd_val);
    chk_inst(1, h1, q1.size(), mdrop1, rif1.rd_valid, count1, full1, drop1, rif1.rd_ts, rif1.rd_aktv, rif1.rd_val);
  endtask

  task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n++; assert (got === exp) else begin errs++; $error("FAIL %s got %0d exp %0d", tag, got, exp); end
  endtask

  task automatic cyc();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_val();
    for (int i = 0; i < N*DW/32; i++) val[i*32 +: 32] = $urandom;
  endtask

  task automatic set_rdy(input logic r);
    rif0.rd_ready = r; rif1.rd_ready = r;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; aktv = '0; val = '0; set_rdy(1'b0);
    cyc(); cyc();
    chk("rst_ts0", rif0.rd_ts, 0);
    chk("rst_aktv1", TW'(rif1.rd_aktv), 0);
    chk("rst_val0", rif0.rd_val[31:0], 0);

    // idle enabled cycles capture nothing
    rst = 1'b0; en = 1'b1;
    repeat (10) begin rand_val(); cyc(); end
    chk("idle_count0", TW'(count0), 0);
    chk("idle_drop0", TW'(drop0), 0);

    // single capture at ts=5
    rst = 1'b1; cyc(); rst = 1'b0;
    repeat (5) cyc();
    rand_val(); val[DW-1:0] = 64'd1; aktv = 12'h001;
    cyc();
    aktv = '0;
    chk("single_ts", rif0.rd_ts, 5);
    chk("single_aktv", TW'(rif0.rd_aktv), 1);
    chk("single_val0", rif0.rd_val[31:0], 1);
    set_rdy(1'b1); cyc(); set_rdy(1'b0);
    chk("single_pop", TW'(rif0.rd_valid), 0);

    // six captures into a DEPTH=4 FIFO without reading
    rst = 1'b1; cyc(); rst = 1'b0;
    repeat (6) begin rand_val(); aktv = N'($urandom_range(1, 4095)); cyc(); end
    aktv = '0;
    chk("ovf_count0", TW'(count0), 4);
    chk("ovf_drop0", TW'(drop0), 2);
    chk("ovf_drop1", TW'(drop1), 2);
    chk("ovf_head0", rif0.rd_ts, 0);
    chk("ovf_head1", rif1.rd_ts, 2);
    set_rdy(1'b1); repeat (5) cyc(); set_rdy(1'b0);

    // full, then capture and pop together, then frozen timestamp while draining
    rst = 1'b1; cyc(); rst = 1'b0;
    repeat (4) begin rand_val(); aktv = N'($urandom_range(1, 4095)); cyc(); end
    rand_val(); set_rdy(1'b1); cyc();
    chk("cap_pop_count1", TW'(count1), 4);
    chk("cap_pop_drop1", TW'(drop1), 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin set_rdy(i[0]); rand_val(); cyc(); end
    en = 1'b1; set_rdy(1'b0); rand_val(); cyc();
    aktv = '0; set_rdy(1'b1); repeat (6) cyc(); set_rdy(1'b0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      en = ($urandom_range(0, 3) != 0);
      aktv = ($urandom_range(0, 1) == 1) ? N'($urandom_range(1, 4095)) : '0;
      rand_val();
      rif0.rd_ready = $urandom_range(0, 2) == 0;
      rif1.rd_ready = $urandom_range(0, 2) == 0;
      cyc();
    end
    rst = 1'b0; en = 1'b1;

    // reset mid-operation with three stored entries
    rst = 1'b1; set_rdy(1'b0); cyc(); rst = 1'b0;
    repeat (3) begin rand_val(); aktv = N'($urandom_range(1, 4095)); cyc(); end
    chk("pre_rst_count0", TW'(count0), 3);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("post_rst_count0", TW'(count0), 0);
    chk("post_rst_valid1", TW'(rif1.rd_valid), 0);
    rand_val(); aktv = 12'h800; cyc(); aktv = '0;
    chk("post_rst_ts0", rif0.rd_ts, 0);
    chk("post_rst_ts1", rif1.rd_ts, 0);

    $display("Result: errors=%0d of %0d checks", errs, n);
    $finish;
  end
endmodule
